// File: rtl/viterbi_ber_checker_if.sv
// Bus bundle for the BER checker: encoder/decoder bit streams in, measurement results out.
interface viterbi_ber_checker_if #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 16
);
  logic             clear;
  logic             tx_valid;
  logic             tx_bit;
  logic             rx_valid;
  logic             rx_bit;
  logic [CNT_W-1:0] bits;
  logic [CNT_W-1:0] errs;
  logic [WIN_W-1:0] win_errs;
  logic             win_done;
  logic             alarm;
  logic             overflow;
  logic             underflow;
  logic [1:0]       state;

  modport master (
    output clear, tx_valid, tx_bit, rx_valid, rx_bit,
    input  bits, errs, win_errs, win_done, alarm, overflow, underflow, state
  );

  modport slave (
    input  clear, tx_valid, tx_bit, rx_valid, rx_bit,
    output bits, errs, win_errs, win_done, alarm, overflow, underflow, state
  );
endinterface

// File: rtl/viterbi_ber_checker.sv
// Receive-side BER checker: buffers transmitted bits in an in-order FIFO and
// compares them against Viterbi decoder output, with windowed error alarm.
module viterbi_ber_checker #(
  parameter int DEPTH        = 64,
  parameter int SKIP_BITS    = 16,
  parameter int WINDOW       = 1024,
  parameter int WIN_W        = 16,
  parameter int ALARM_THRESH = 64,
  parameter int CNT_W        = 32
) (
  input logic                  clk,
  input logic                  rst,
  viterbi_ber_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SKIP_BITS > 1) ? $clog2(SKIP_BITS) : 1;
  localparam int WB = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SW-1:0]  SKIP_LAST = SW'((SKIP_BITS > 0) ? SKIP_BITS - 1 : 0);
  localparam logic [WB-1:0]  WIN_LAST  = WB'(WINDOW - 1);
  localparam logic [WIN_W:0] THRESH_V  = (WIN_W + 1)'(ALARM_THRESH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             active;
  logic             bypass;
  logic             unf_evt;
  logic             ovf_evt;
  logic             fault_evt;
  logic             do_push;
  logic             do_pop;
  logic             cmp_valid;
  logic             ref_bit;
  logic             mismatch;
  logic             count_en;
  logic             skip_en;
  logic             win_last;
  logic [SW-1:0]    skip_cnt;
  logic [WB-1:0]    win_bits;
  logic [WIN_W-1:0] win_acc;
  logic [WIN_W-1:0] win_acc_nxt;
  logic [WIN_W-1:0] win_errs_q;
  logic [CNT_W-1:0] bits_q;
  logic [CNT_W-1:0] errs_q;
  logic             win_done_q;
  logic             alarm_q;
  logic             ovf_q;
  logic             unf_q;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign active    = (state != FAULT);
  assign bypass    = active && bus.rx_valid && bus.tx_valid && empty;
  assign unf_evt   = active && bus.rx_valid && !bus.tx_valid && empty;
  assign ovf_evt   = active && bus.tx_valid && !bus.rx_valid && full;
  assign fault_evt = unf_evt || ovf_evt;
  assign do_pop    = active && bus.rx_valid && !empty;
  assign do_push   = active && bus.tx_valid && !bypass && !ovf_evt;
  assign cmp_valid = do_pop || bypass;

  // An empty FIFO can only reach a compare through the bypass path.
  assign ref_bit     = empty ? bus.tx_bit : mem[rd_ptr[AW-1:0]];
  assign mismatch    = bus.rx_bit ^ ref_bit;
  assign win_last    = (win_bits == WIN_LAST);
  assign win_acc_nxt = (mismatch && (win_acc != '1)) ? win_acc + 1'b1 : win_acc;

  always_ff @(posedge clk) begin
    if (do_push && !bus.clear) begin
      mem[wr_ptr[AW-1:0]] <= bus.tx_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (bus.clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // With SKIP_BITS of 1 the first pop already completes warm-up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fault_evt)      state_nxt = FAULT;
        else if (cmp_valid) state_nxt = (SKIP_BITS <= 1) ? RUN : WARMUP;
      end
      WARMUP: begin
        if (fault_evt)                               state_nxt = FAULT;
        else if (cmp_valid && skip_cnt == SKIP_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (fault_evt) state_nxt = FAULT;
      end
      default: state_nxt = FAULT;
    endcase
  end

  always_comb begin
    count_en = 1'b0;
    skip_en  = 1'b0;
    case (state)
      IDLE: begin
        if (SKIP_BITS == 0) count_en = cmp_valid;
        else                skip_en  = cmp_valid;
      end
      WARMUP:  skip_en  = cmp_valid;
      RUN:     count_en = cmp_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_cnt   <= '0;
      win_bits   <= '0;
      win_acc    <= '0;
      win_errs_q <= '0;
      bits_q     <= '0;
      errs_q     <= '0;
      win_done_q <= 1'b0;
      alarm_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (bus.clear) begin
      skip_cnt   <= '0;
      win_bits   <= '0;
      win_acc    <= '0;
      win_errs_q <= '0;
      bits_q     <= '0;
      errs_q     <= '0;
      win_done_q <= 1'b0;
      alarm_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      win_done_q <= 1'b0;
      if (skip_en) skip_cnt <= skip_cnt + 1'b1;
      if (count_en) begin
        if (bits_q != '1)             bits_q <= bits_q + 1'b1;
        if (mismatch && errs_q != '1) errs_q <= errs_q + 1'b1;
        if (win_last) begin
          win_errs_q <= win_acc_nxt;
          win_done_q <= 1'b1;
          if ({1'b0, win_acc_nxt} > THRESH_V) alarm_q <= 1'b1;
          win_bits   <= '0;
          win_acc    <= '0;
        end else begin
          win_bits   <= win_bits + 1'b1;
          win_acc    <= win_acc_nxt;
        end
      end
      if (ovf_evt) ovf_q <= 1'b1;
      if (unf_evt) unf_q <= 1'b1;
    end
  end

  assign bus.bits      = bits_q;
  assign bus.errs      = errs_q;
  assign bus.win_errs  = win_errs_q;
  assign bus.win_done  = win_done_q;
  assign bus.alarm     = alarm_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.state     = state;
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Scoreboard bench for viterbi_ber_checker: three differently parameterised
// instances share one random stimulus stream and are checked against a reference model.
module tb_viterbi_ber_checker;
  typedef struct packed {
    logic [31:0] bits;
    logic [31:0] errs;
    logic [15:0] win_errs;
    logic        win_done;
    logic        alarm;
    logic        overflow;
    logic        underflow;
    logic [1:0]  state;
  } snap_t;
  typedef snap_t [2:0] trio_t;

  localparam int    SKIP_P [3] = '{16, 16, 0};
  localparam int    WIN_P  [3] = '{1024, 1024, 64};
  localparam int    THR_P  [3] = '{64, 63, 3};
  localparam int    FDEPTH     = 64;
  localparam longint CMAX      = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_ber_checker_if if_a ();
  viterbi_ber_checker_if if_b ();
  viterbi_ber_checker_if if_c ();

  viterbi_ber_checker #(.DEPTH(64), .SKIP_BITS(16), .WINDOW(1024), .WIN_W(16),
                        .ALARM_THRESH(64), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  viterbi_ber_checker #(.DEPTH(64), .SKIP_BITS(16), .WINDOW(1024), .WIN_W(16),
                        .ALARM_THRESH(63), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  viterbi_ber_checker #(.DEPTH(64), .SKIP_BITS(0), .WINDOW(64), .WIN_W(16),
                        .ALARM_THRESH(3), .CNT_W(32)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wd_a     = 0;
  int wd_c     = 0;
  trio_t expq [$];

  // Reference model: a plain array FIFO plus counts derived from the pop index.
  bit     mfifo [3][FDEPTH];
  int     mhead [3];
  int     mcount[3];
  int     pops  [3];
  int     wbits [3];
  int     wacc  [3];
  int     werrs [3];
  longint mbits [3];
  longint merrs [3];
  bit     wdone [3];
  bit     malarm[3];
  bit     movf  [3];
  bit     munf  [3];
  bit     mfault[3];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    mhead[i] = 0; mcount[i] = 0; pops[i] = 0; wbits[i] = 0; wacc[i] = 0; werrs[i] = 0;
    mbits[i] = 0; merrs[i] = 0; wdone[i] = 0; malarm[i] = 0; movf[i] = 0; munf[i] = 0;
    mfault[i] = 0;
  endtask

  task automatic model_step(input int i, input bit tv, input bit tb_, input bit rv,
                            input bit rb, input bit cl, input bit rl);
    bit refb;
    bit byp;
    wdone[i] = 1'b0;
    if (cl || rl) begin
      model_reset(i);
      return;
    end
    if (mfault[i]) return;
    if (rv && !tv && mcount[i] == 0) begin
      munf[i] = 1'b1; mfault[i] = 1'b1;
      return;
    end
    if (tv && !rv && mcount[i] == FDEPTH) begin
      movf[i] = 1'b1; mfault[i] = 1'b1;
      return;
    end
    byp  = rv && tv && (mcount[i] == 0);
    refb = tb_;
    if (rv && !byp) begin
      refb = mfifo[i][mhead[i]];
      mhead[i] = (mhead[i] + 1) % FDEPTH;
      mcount[i]--;
    end
    if (tv && !byp) begin
      mfifo[i][(mhead[i] + mcount[i]) % FDEPTH] = tb_;
      mcount[i]++;
    end
    if (rv) begin
      pops[i]++;
      if (pops[i] > SKIP_P[i]) begin
        if (mbits[i] < CMAX) mbits[i]++;
        if (rb != refb) begin
          if (merrs[i] < CMAX) merrs[i]++;
          if (wacc[i] < 65535) wacc[i]++;
        end
        wbits[i]++;
        if (wbits[i] == WIN_P[i]) begin
          werrs[i] = wacc[i];
          wdone[i] = 1'b1;
          if (wacc[i] > THR_P[i]) malarm[i] = 1'b1;
          wbits[i] = 0;
          wacc[i]  = 0;
        end
      end
    end
  endtask

  function automatic snap_t model_snap(input int i);
    snap_t s;
    s.bits      = mbits[i][31:0];
    s.errs      = merrs[i][31:0];
    s.win_errs  = werrs[i][15:0];
    s.win_done  = wdone[i];
    s.alarm     = malarm[i];
    s.overflow  = movf[i];
    s.underflow = munf[i];
    if (mfault[i])              s.state = 2'd3;
    else if (pops[i] == 0)      s.state = 2'd0;
    else if (pops[i] < SKIP_P[i]) s.state = 2'd1;
    else                        s.state = 2'd2;
    return s;
  endfunction

  function automatic snap_t dut_snap(input int i);
    snap_t s;
    case (i)
      0:       s = {if_a.bits, if_a.errs, if_a.win_errs, if_a.win_done, if_a.alarm,
                    if_a.overflow, if_a.underflow, if_a.state};
      1:       s = {if_b.bits, if_b.errs, if_b.win_errs, if_b.win_done, if_b.alarm,
                    if_b.overflow, if_b.underflow, if_b.state};
      default: s = {if_c.bits, if_c.errs, if_c.win_errs, if_c.win_done, if_c.alarm,
                    if_c.overflow, if_c.underflow, if_c.state};
    endcase
    return s;
  endfunction

  // One cycle of stimulus; rl pulses the async reset low before the next edge.
  task automatic applyStimulus(input bit tv, input bit tb_, input bit rv, input bit rb,
                               input bit cl, input bit rl);
    trio_t e;
    @(negedge clk);
    rst = 1'b1;
    if_a.tx_valid = tv; if_a.tx_bit = tb_; if_a.rx_valid = rv; if_a.rx_bit = rb; if_a.clear = cl;
    if_b.tx_valid = tv; if_b.tx_bit = tb_; if_b.rx_valid = rv; if_b.rx_bit = rb; if_b.clear = cl;
    if_c.tx_valid = tv; if_c.tx_bit = tb_; if_c.rx_valid = rv; if_c.rx_bit = rb; if_c.clear = cl;
    for (int i = 0; i < 3; i++) begin
      model_step(i, tv, tb_, rv, rb, cl, rl);
      e[i] = model_snap(i);
    end
    expq.push_back(e);
    if (rl) begin
      #2 rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) checkOutput($sformatf("async_zero[%0d]", i), dut_snap(i), '0);
    end
  endtask

  task automatic applyIdle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // rx lags tx by 10 cycles; optional injected errors and early stop points.
  task automatic runStream(input int n, input bit inject, input int stop_a, input bit stop_c);
    bit txs  [2048];
    int fpos [128];
    for (int k = 0; k < n; k++)   txs[k]  = 1'($urandom_range(0, 1));
    for (int b = 0; b < 128; b++) fpos[b] = int'($urandom_range(0, 15));
    for (int k = 0; k < n + 10; k++) begin
      bit tv;
      bit tb_;
      bit rv;
      bit rb;
      tv  = (k < n);
      tb_ = tv ? txs[k] : 1'b0;
      rv  = (k >= 10);
      rb  = 1'b0;
      if (rv) begin
        rb = txs[k-10];
        if (inject && (k - 10) >= 16 && ((k - 10) % 16) == fpos[(k-10)/16]) rb = ~rb;
      end
      if (stop_a > 0 && mbits[0] == stop_a) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        return;
      end
      if (stop_c && rv && wbits[2] == WIN_P[2] - 1) begin
        applyStimulus(tv, tb_, rv, rb, 1'b0, 1'b1);
        return;
      end
      applyStimulus(tv, tb_, rv, rb, 1'b0, 1'b0);
    end
  endtask

  task automatic clearAll();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyIdle(1);
  endtask

  always @(posedge clk) begin : monitor
    trio_t e;
    #1;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      for (int i = 0; i < 3; i++) checkOutput($sformatf("snap[%0d] cyc %0d", i, cyc), dut_snap(i), e[i]);
      if (if_a.win_done) wd_a++;
      if (if_c.win_done) wd_c++;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int wd_before;
    if_a.clear = 0; if_a.tx_valid = 0; if_a.tx_bit = 0; if_a.rx_valid = 0; if_a.rx_bit = 0;
    if_b.clear = 0; if_b.tx_valid = 0; if_b.tx_bit = 0; if_b.rx_valid = 0; if_b.rx_bit = 0;
    if_c.clear = 0; if_c.tx_valid = 0; if_c.tx_bit = 0; if_c.rx_valid = 0; if_c.rx_bit = 0;
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset[%0d]", i), dut_snap(i), '0);
      model_reset(i);
    end
    applyIdle(2);

    $display("[TB] identical streams");
    wd_a = 0; wd_c = 0;
    runStream(2048, 1'b0, 0, 1'b0);
    applyIdle(3);
    checkOutput("ident_bits_a", if_a.bits, 2032);
    checkOutput("ident_errs_a", if_a.errs, 0);
    checkOutput("ident_winerrs_a", if_a.win_errs, 0);
    checkOutput("ident_alarm_a", if_a.alarm, 0);
    checkOutput("ident_windone_a", wd_a, 1);
    checkOutput("ident_bits_c", if_c.bits, 2048);
    checkOutput("ident_windone_c", wd_c, 32);
    clearAll();

    $display("[TB] injected errors");
    runStream(2048, 1'b1, 0, 1'b0);
    applyIdle(3);
    checkOutput("inj_errs_a", if_a.errs, 127);
    checkOutput("inj_winerrs_a", if_a.win_errs, 64);
    checkOutput("inj_alarm_a", if_a.alarm, 0);
    checkOutput("inj_alarm_b", if_b.alarm, 1);
    clearAll();

    $display("[TB] bypass and underflow");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyIdle(2);
    checkOutput("byp_bits_c", if_c.bits, 1);
    checkOutput("byp_errs_c", if_c.errs, 1);
    checkOutput("byp_unf_a", if_a.underflow, 0);
    checkOutput("byp_state_a", if_a.state, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyIdle(1);
    checkOutput("unf_flag_a", if_a.underflow, 1);
    checkOutput("unf_state_a", if_a.state, 3);
    for (int k = 0; k < 50; k++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    applyIdle(1);
    checkOutput("unf_frozen_c", if_c.bits, 1);
    clearAll();

    $display("[TB] overflow");
    for (int k = 0; k < 64; k++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    applyIdle(1);
    checkOutput("full_pushpop_ovf_a", if_a.overflow, 0);
    checkOutput("full_pushpop_state_a", if_a.state, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyIdle(1);
    checkOutput("ovf_flag_a", if_a.overflow, 1);
    checkOutput("ovf_state_a", if_a.state, 3);
    clearAll();

    $display("[TB] clear mid-run");
    runStream(2048, 1'b0, 500, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("clear_bits_a", if_a.bits, 0);
    checkOutput("clear_state_a", if_a.state, 0);
    runStream(100, 1'b0, 0, 1'b0);
    applyIdle(3);
    checkOutput("restart_bits_a", if_a.bits, 84);
    checkOutput("restart_bits_c", if_c.bits, 100);
    clearAll();

    $display("[TB] async reset with window pending");
    wd_before = wd_c;
    runStream(2048, 1'b0, 0, 1'b1);
    applyIdle(5);
    checkOutput("rst_no_windone_c", wd_c, wd_before);
    runStream(20, 1'b0, 0, 1'b0);
    applyIdle(3);
    checkOutput("rst_restart_bits_c", if_c.bits, 20);
    checkOutput("rst_restart_bits_a", if_a.bits, 4);

    applyIdle(2);
    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
